// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared definitions for the register-file port arbiter: the arbiter state
//   encoding and the default register-file geometry used by regfile_arbiter.
//   No ports (package).
package regfile_arb_pkg;

  // Arbiter states. CLEAR is the reset state so the encoding of zero is the
  // one the register comes up in.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    PROC  = 2'd1,
    TEST  = 2'd2
  } arb_state_t;

  // Default register-file geometry.
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/regfile_port_mux.sv
// regfile_port_mux
//   Three-way select of the register-file control/data port between the
//   hardware-clear bundle, the processor bundle and the test-harness bundle.
//   Each bundle is packed as {writeEnable, writeReg, readRegA, readRegB, data}.
// Ports:
//   state    in   current arbiter state, selects the source bundle
//   clr_bus  in   bundle generated by the clear sequencer
//   p_bus    in   bundle from the processor
//   t_bus    in   bundle from the test harness
//   r_bus    out  selected bundle towards the register file
module regfile_port_mux
  import regfile_arb_pkg::*;
#(
  parameter int BUS_W = 1
) (
  input  arb_state_t       state,
  input  logic [BUS_W-1:0] clr_bus,
  input  logic [BUS_W-1:0] p_bus,
  input  logic [BUS_W-1:0] t_bus,
  output logic [BUS_W-1:0] r_bus
);

  always_comb begin
    // NOTE: default assignment first so every path drives r_bus and no latch
    // is inferred; the unused encoding selects an idle (no-write) port.
    r_bus = '0;
    case (state)
      CLEAR:   r_bus = clr_bus;
      PROC:    r_bus = p_bus;
      TEST:    r_bus = t_bus;
      default: r_bus = '0;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Owns the register file's single control/data port. After reset it walks
//   every register index writing zero, then grants the port to the processor
//   and hands it to the test harness while t_req is held, stalling the
//   processor for as long as the harness (or the clear) owns the port.
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   p_writeEnable, p_writeReg,
//   p_readRegA, p_readRegB,
//   p_data_writeReg               processor port request
//   t_req                         harness requests the port (level)
//   t_writeEnable, t_writeReg,
//   t_readRegA, t_readRegB,
//   t_data_writeReg               harness port request
//   r_ctrl_writeEnable, r_ctrl_writeReg,
//   r_ctrl_readRegA, r_ctrl_readRegB,
//   r_data_writeReg               port driven into the register file
//   t_grant                       harness owns the port this cycle
//   p_stall                       processor must hold its current operation
//   clear_done                    hardware clear has finished
//   t_write_count                 saturating count of harness writes performed
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_writeEnable,
  input  logic [ADDR_W-1:0] p_writeReg,
  input  logic [ADDR_W-1:0] p_readRegA,
  input  logic [ADDR_W-1:0] p_readRegB,
  input  logic [DATA_W-1:0] p_data_writeReg,
  input  logic              t_req,
  input  logic              t_writeEnable,
  input  logic [ADDR_W-1:0] t_writeReg,
  input  logic [ADDR_W-1:0] t_readRegA,
  input  logic [ADDR_W-1:0] t_readRegB,
  input  logic [DATA_W-1:0] t_data_writeReg,
  output logic              r_ctrl_writeEnable,
  output logic [ADDR_W-1:0] r_ctrl_writeReg,
  output logic [ADDR_W-1:0] r_ctrl_readRegA,
  output logic [ADDR_W-1:0] r_ctrl_readRegB,
  output logic [DATA_W-1:0] r_data_writeReg,
  output logic              t_grant,
  output logic              p_stall,
  output logic              clear_done,
  output logic [CNT_W-1:0]  t_write_count
);

  localparam int BUS_W = 1 + 3 * ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  logic [BUS_W-1:0]  clr_bus;
  logic [BUS_W-1:0]  p_bus;
  logic [BUS_W-1:0]  t_bus;
  logic [BUS_W-1:0]  mux_bus;

  // FSM, clear index and harness write counter. The clear always runs to
  // completion once started; t_req is only looked at on its final cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: all state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_REG) begin
            state <= t_req ? TEST : PROC;
          end
        end
        PROC: begin
          if (t_req) begin
            state <= TEST;
          end
        end
        TEST: begin
          if (t_writeEnable && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
          if (!t_req) begin
            state <= PROC;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Clear sequencer writes zero to the current index with reads parked at 0.
  assign clr_bus = {1'b1, clr_cnt, {ADDR_W{1'b0}}, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
  assign p_bus   = {p_writeEnable, p_writeReg, p_readRegA, p_readRegB, p_data_writeReg};
  assign t_bus   = {t_writeEnable, t_writeReg, t_readRegA, t_readRegB, t_data_writeReg};

  regfile_port_mux #(
    .BUS_W (BUS_W)
  ) u_port_mux (
    .state   (state),
    .clr_bus (clr_bus),
    .p_bus   (p_bus),
    .t_bus   (t_bus),
    .r_bus   (mux_bus)
  );

  // Reset is synchronous, so the registers only settle at the first edge;
  // gating with reset keeps the regfile port idle and the status outputs
  // defined for the whole time reset is high, including before that edge.
  assign {r_ctrl_writeEnable, r_ctrl_writeReg, r_ctrl_readRegA,
          r_ctrl_readRegB, r_data_writeReg} = reset ? '0 : mux_bus;

  assign t_grant       = !reset && (state == TEST);
  assign p_stall       = reset || (state != PROC);
  assign clear_done    = !reset && (state != CLEAR);
  assign t_write_count = reset ? '0 : wr_cnt;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
//   Directed bench for regfile_arbiter. Each cycle drives inputs just after
//   the rising edge, queues the expected output vector, and compares it on the
//   falling edge. Output vector: {we, writeReg, readA, readB, data, grant,
//   stall, clear_done, write_count}.
module tb_regfile_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int VEC_W  = 1 + 3 * ADDR_W + DATA_W + 3 + CNT_W;

  typedef struct {
    string            tag;
    logic [VEC_W-1:0] vec;
  } exp_t;

  logic              clock;
  logic              reset;
  logic              p_writeEnable;
  logic [ADDR_W-1:0] p_writeReg, p_readRegA, p_readRegB;
  logic [DATA_W-1:0] p_data_writeReg;
  logic              t_req;
  logic              t_writeEnable;
  logic [ADDR_W-1:0] t_writeReg, t_readRegA, t_readRegB;
  logic [DATA_W-1:0] t_data_writeReg;
  logic              r_ctrl_writeEnable;
  logic [ADDR_W-1:0] r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB;
  logic [DATA_W-1:0] r_data_writeReg;
  logic              t_grant, p_stall, clear_done;
  logic [CNT_W-1:0]  t_write_count;

  logic [VEC_W-1:0]  obs;
  exp_t              exp_q[$];
  int                checks   = 0;
  int                failures = 0;

  regfile_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .p_writeEnable      (p_writeEnable),
    .p_writeReg         (p_writeReg),
    .p_readRegA         (p_readRegA),
    .p_readRegB         (p_readRegB),
    .p_data_writeReg    (p_data_writeReg),
    .t_req              (t_req),
    .t_writeEnable      (t_writeEnable),
    .t_writeReg         (t_writeReg),
    .t_readRegA         (t_readRegA),
    .t_readRegB         (t_readRegB),
    .t_data_writeReg    (t_data_writeReg),
    .r_ctrl_writeEnable (r_ctrl_writeEnable),
    .r_ctrl_writeReg    (r_ctrl_writeReg),
    .r_ctrl_readRegA    (r_ctrl_readRegA),
    .r_ctrl_readRegB    (r_ctrl_readRegB),
    .r_data_writeReg    (r_data_writeReg),
    .t_grant            (t_grant),
    .p_stall            (p_stall),
    .clear_done         (clear_done),
    .t_write_count      (t_write_count)
  );

  assign obs = {r_ctrl_writeEnable, r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB,
                r_data_writeReg, t_grant, p_stall, clear_done, t_write_count};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [VEC_W-1:0] exp_vec(
    input logic we, input logic [ADDR_W-1:0] wr, input logic [ADDR_W-1:0] ra,
    input logic [ADDR_W-1:0] rb, input logic [DATA_W-1:0] data, input logic g,
    input logic s, input logic d, input logic [CNT_W-1:0] c);
    return {we, wr, ra, rb, data, g, s, d, c};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_p(input logic we, input logic [ADDR_W-1:0] wr,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                       input logic [DATA_W-1:0] data);
    p_writeEnable = we; p_writeReg = wr; p_readRegA = ra; p_readRegB = rb;
    p_data_writeReg = data;
  endtask

  task automatic set_t(input logic req, input logic we, input logic [ADDR_W-1:0] wr,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                       input logic [DATA_W-1:0] data);
    t_req = req; t_writeEnable = we; t_writeReg = wr; t_readRegA = ra;
    t_readRegB = rb; t_data_writeReg = data;
  endtask

  // Queue the expectation for the stimulus just driven, then compare it
  // against the DUT on the falling edge.
  task automatic step(input string tag, input logic [VEC_W-1:0] v);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.vec = v;
    exp_q.push_back(e);
    @(negedge clock);
    got = exp_q.pop_front();
    checks++;
    assert (obs === got.vec)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", got.tag, obs, got.vec);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_p(1'b0, '0, '0, '0, '0);
    set_t(1'b0, 1'b0, '0, '0, '0, '0);

    // Reset held 3 cycles with busy inputs: port idle, stalled, nothing done.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      reset = 1'b1;
      set_p(1'b1, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF);
      set_t(1'b1, 1'b1, 5'd6, 5'd7, 5'd8, 32'hCAFE_F00D);
      step("reset_hold", exp_vec(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0));
    end

    // Clear sweep 0..31 with zero data; processor request must not leak.
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      reset = 1'b0;
      set_t(1'b0, 1'b1, 5'd6, 5'd7, 5'd8, 32'hCAFE_F00D);
      step($sformatf("clear_%0d", i),
           exp_vec(1'b1, 5'(i), '0, '0, '0, 1'b0, 1'b1, 1'b0, '0));
    end

    next_cycle();
    set_p(1'b1, 5'd5, 5'd1, 5'd2, 32'h0000_00AA);
    set_t(1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 32'h0000_0BAD);
    step("proc_write_5", exp_vec(1'b1, 5'd5, 5'd1, 5'd2, 32'hAA, 1'b0, 1'b0, 1'b1, '0));

    next_cycle();
    set_p(1'b0, 5'd6, 5'd3, 5'd4, 32'h0000_0055);
    set_t(1'b0, 1'b0, 5'd20, 5'd21, 5'd22, 32'h0000_0BAD);
    step("proc_idle", exp_vec(1'b0, 5'd6, 5'd3, 5'd4, 32'h55, 1'b0, 1'b0, 1'b1, '0));

    // t_req rises together with a processor write: that write still passes,
    // and the simultaneous harness write is discarded and uncounted.
    next_cycle();
    set_p(1'b1, 5'd7, 5'd8, 5'd9, 32'h0000_0011);
    set_t(1'b1, 1'b1, 5'd9, 5'd10, 5'd11, 32'h0000_0022);
    step("handover_proc_write", exp_vec(1'b1, 5'd7, 5'd8, 5'd9, 32'h11, 1'b0, 1'b0, 1'b1, '0));

    next_cycle();
    step("test_write_9", exp_vec(1'b1, 5'd9, 5'd10, 5'd11, 32'h22, 1'b1, 1'b1, 1'b1, '0));

    // t_req falls: one more TEST cycle, count now shows the single write.
    next_cycle();
    set_t(1'b0, 1'b0, 5'd12, 5'd13, 5'd14, 32'h0000_0033);
    step("release_latency", exp_vec(1'b0, 5'd12, 5'd13, 5'd14, 32'h33, 1'b1, 1'b1, 1'b1, 16'd1));

    // Held processor write completes after return to PROC.
    next_cycle();
    step("proc_resume", exp_vec(1'b1, 5'd7, 5'd8, 5'd9, 32'h11, 1'b0, 1'b0, 1'b1, 16'd1));

    // One-cycle t_req pulse gives exactly one TEST cycle.
    next_cycle();
    set_p(1'b1, 5'd15, 5'd16, 5'd17, 32'h0000_0044);
    set_t(1'b1, 1'b1, 5'd18, 5'd19, 5'd20, 32'h0000_0066);
    step("pulse_rise", exp_vec(1'b1, 5'd15, 5'd16, 5'd17, 32'h44, 1'b0, 1'b0, 1'b1, 16'd1));

    next_cycle();
    set_t(1'b0, 1'b1, 5'd18, 5'd19, 5'd20, 32'h0000_0066);
    step("pulse_test", exp_vec(1'b1, 5'd18, 5'd19, 5'd20, 32'h66, 1'b1, 1'b1, 1'b1, 16'd1));

    next_cycle();
    step("pulse_back", exp_vec(1'b1, 5'd15, 5'd16, 5'd17, 32'h44, 1'b0, 1'b0, 1'b1, 16'd2));

    // Enter TEST again, then reset while the harness owns the port.
    next_cycle();
    set_t(1'b1, 1'b0, 5'd21, 5'd22, 5'd23, 32'h0000_0077);
    step("pre_reset_req", exp_vec(1'b1, 5'd15, 5'd16, 5'd17, 32'h44, 1'b0, 1'b0, 1'b1, 16'd2));

    next_cycle();
    set_t(1'b1, 1'b1, 5'd21, 5'd22, 5'd23, 32'h0000_0077);
    step("test_before_reset", exp_vec(1'b1, 5'd21, 5'd22, 5'd23, 32'h77, 1'b1, 1'b1, 1'b1, 16'd2));

    next_cycle();
    reset = 1'b1;
    step("reset_in_test", exp_vec(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0));

    // Clear restarts from index 0; t_req raised at cycle 10 is held off
    // until the sweep ends, then the port goes straight to the harness.
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      reset = 1'b0;
      set_t(i >= 10, 1'b1, 5'd25, 5'd26, 5'd27, 32'h0000_0099);
      step($sformatf("clear2_%0d", i),
           exp_vec(1'b1, 5'(i), '0, '0, '0, 1'b0, 1'b1, 1'b0, '0));
    end

    // Back-to-back harness writes drive the counter into saturation.
    for (int k = 0; k <= 65540; k++) begin
      next_cycle();
      set_t(1'b1, 1'b1, 5'd25, 5'd26, 5'd27, 32'h0000_0099);
      step("saturate", exp_vec(1'b1, 5'd25, 5'd26, 5'd27, 32'h99, 1'b1, 1'b1, 1'b1,
                               (k >= 65535) ? 16'hFFFF : 16'(k)));
    end

    next_cycle();
    set_t(1'b0, 1'b1, 5'd25, 5'd26, 5'd27, 32'h0000_0099);
    step("sat_release", exp_vec(1'b1, 5'd25, 5'd26, 5'd27, 32'h99, 1'b1, 1'b1, 1'b1, 16'hFFFF));

    next_cycle();
    step("sat_proc", exp_vec(1'b1, 5'd15, 5'd16, 5'd17, 32'h44, 1'b0, 1'b0, 1'b1, 16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Owns the register file's single control/data port and shares it between the processor and the external test harness. On reset it first sequences a hardware clear of every register. It then grants the port to the processor by default and hands it to the test harness on request, stalling the processor while the harness owns it. It sits between the processor's regfile outputs, the test inputs and the regfile instance, and replaces the static test-select muxes.

## Interface
- NUM_REGS, 32, number of registers cleared (power of two)
- ADDR_W, 5, register index width (log2 NUM_REGS)
- DATA_W, 32, register data width
- CNT_W, 16, width of test write counter

- clock  in  1  regfile/processor clock (same net as regfile)
- reset  in  1  synchronous, active-high
- p_writeEnable  in  1  processor write enable
- p_writeReg, p_readRegA, p_readRegB  in  ADDR_W  processor register indices
- p_data_writeReg  in  DATA_W  processor write data
- t_req  in  1  test harness requests port (level)
- t_writeEnable  in  1  test write enable
- t_writeReg, t_readRegA, t_readRegB  in  ADDR_W  test register indices
- t_data_writeReg  in  DATA_W  test write data
- r_ctrl_writeEnable  out  1  to regfile
- r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB  out  ADDR_W  to regfile
- r_data_writeReg  out  DATA_W  to regfile
- t_grant  out  1  harness owns port this cycle
- p_stall  out  1  processor must hold (no PC advance, no writeback)
- clear_done  out  1  hardware clear finished
- t_write_count  out  CNT_W  saturating count of test writes performed

## Operation
- States: CLEAR, PROC, TEST. State register resets to CLEAR; clear counter to 0; t_write_count to 0.
- CLEAR: r_ctrl_writeEnable=1, r_ctrl_writeReg=clr_cnt, r_data_writeReg=0, read indices=0. clr_cnt increments each cycle. At clr_cnt==NUM_REGS-1: next = TEST if t_req else PROC. Register 0 is included.
- PROC: all r_* outputs driven from p_* combinationally. If t_req=1, next=TEST. Otherwise stay.
- TEST: all r_* outputs driven from t_*. Each cycle with t_writeEnable=1, t_write_count increments, saturating at all-ones. If t_req=0, next=PROC.
- Outputs are combinational decodes of state:
  - t_grant = (state==TEST)
  - p_stall = (state!=PROC)
  - clear_done = (state!=CLEAR)
- The processor write in the PROC cycle where t_req rises is performed. Handover takes effect the following cycle.
- Processor writes while p_stall=1 are never forwarded. The processor holds them, and they complete after return to PROC.
- t_req during CLEAR is ignored until the clear completes. The clear is never aborted except by reset.
- t_* writes while t_grant=0 are discarded and not counted.

## Timing
- While reset=1: r_ctrl_writeEnable forced 0, t_grant=0, p_stall=1, clear_done=0, t_write_count=0. r_ctrl_writeReg, r_ctrl_readRegA/B and r_data_writeReg are all 0.
- Clear occupies exactly NUM_REGS cycles after the first clock with reset=0. clear_done rises on cycle NUM_REGS.
- Grant latency is 1 cycle from t_req rising, sampled at the clock edge. Release latency is 1 cycle from t_req falling.
- A t_req pulse of one cycle in PROC yields exactly one TEST cycle.
- Reset mid-operation, in any state, returns to CLEAR next edge and restarts the count at 0. t_write_count is zeroed.

## Structure
- Package regfile_arb_pkg holds:
  - the state encoding (CLEAR=2'd0, PROC=2'd1, TEST=2'd2)
  - default widths ADDR_W/DATA_W/NUM_REGS
- One combinational sub-module, regfile_port_mux: a 3-way select of {clear, processor, test} port bundles by state.
- FSM, clear counter and write counter live in the top module.

## Test plan
- Reset held 3 cycles, then released:
  - r_ctrl_writeEnable=1 with writeReg 0..31 and data 0 on 32 consecutive cycles.
  - clear_done=1 on cycle 32, p_stall=0, t_grant=0.
- After clear, processor writes reg 5 = 0x0000_00AA with t_req=0 -> r_ctrl_writeReg=5, data 0xAA, writeEnable=1 on the same cycle.
- t_req=1 while p_writeEnable=1 (reg 7=0x11):
  - That write passes.
  - Next cycle t_grant=1, p_stall=1, and t_writeReg 9=0x22 appears on r_*.
  - t_write_count goes 0→1.
- t_req=1 during CLEAR at cycle 10 -> no grant until cycle 32. State goes directly to TEST, p_stall stays 1 throughout.
- Reset asserted while in TEST -> next edge t_grant=0 and t_write_count=0. After release, the full 32-cycle clear repeats from index 0.
- 65540 consecutive test writes -> t_write_count saturates at 0xFFFF.
